// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs a WORDS*N-bit operation through an N-bit ALU one word per cycle, LSW first.
// Define ALU_SEQ_EARLY_ACK_EN to accept the next request in DONE while the response is consumed.
module alu_op_sequencer #(
  parameter int N = 8,
  parameter int WORDS = 2,
  localparam int W = N * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_cin,
  output logic [N-1:0] alu_in0,
  output logic [N-1:0] alu_in1,
  output logic [2:0]   alu_ctrl,
  output logic         alu_c_in,
  input  logic         alu_c_out,
  input  logic [N-1:0] alu_out,
  input  logic         alu_V,
  input  logic         alu_Z,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_c,
  output logic         rsp_v,
  output logic         rsp_z
);
  localparam int KW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state;
  logic [2:0] op;
  logic [W-1:0] a, b, acc, nxt;
  logic cin, carry, zacc, arith, last, take, exec;
  logic [KW-1:0] k;
  assign arith = op[2:1] == 2'b00;
  assign last = k == KW'(WORDS - 1);
  assign exec = state == EXEC;
`ifdef ALU_SEQ_EARLY_ACK_EN
  assign req_ready = !rst && (state == IDLE || (state == DONE && rsp_ready));
`else
  assign req_ready = !rst && state == IDLE;
`endif
  assign take = req_valid && req_ready;
  always_comb begin
    alu_in0 = exec ? a[k*N +: N] : '0;
    alu_in1 = exec ? b[k*N +: N] : '0;
    alu_ctrl = exec ? op : 3'b000;
    alu_c_in = !exec ? 1'b0 : k == '0 ? (op == 3'b000 ? cin : op == 3'b001) : arith & carry;
    nxt = acc;
    nxt[k*N +: N] = alu_out;
  end
  // rsp_result is only updated on the final word so it stays stable through IDLE and EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_c <= 1'b0;
      rsp_v <= 1'b0;
      rsp_z <= 1'b0;
      k <= '0;
      carry <= 1'b0;
      zacc <= 1'b0;
    end else if (take) begin
      op <= req_op;
      a <= req_a;
      b <= req_b;
      cin <= req_cin;
      k <= '0;
      zacc <= 1'b1;
      rsp_valid <= 1'b0;
      state <= EXEC;
    end else if (exec) begin
      acc <= nxt;
      carry <= alu_c_out;
      zacc <= zacc & alu_Z;
      if (last) begin
        rsp_result <= nxt;
        rsp_c <= arith & alu_c_out;
        rsp_v <= arith & alu_V;
        rsp_z <= zacc & alu_Z;
        rsp_valid <= 1'b1;
        state <= DONE;
      end else begin
        k <= k + 1'b1;
      end
    end else if (state == DONE && rsp_ready) begin
      rsp_valid <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench with a word-level ALU model and a full-width reference model.
module tb_alu_op_sequencer;
  localparam int N = 8, WORDS = 2, W = N * WORDS;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid, req_ready, req_cin, alu_c_in, alu_c_out, alu_V, alu_Z;
  logic rsp_valid, rsp_ready, rsp_c, rsp_v, rsp_z;
  logic [2:0] req_op, alu_ctrl;
  logic [W-1:0] req_a, req_b, rsp_result;
  logic [N-1:0] alu_in0, alu_in1, alu_out, y;
  logic [N:0] s;
  always #5 clk = ~clk;

  alu_op_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .alu_in0(alu_in0), .alu_in1(alu_in1),
    .alu_ctrl(alu_ctrl), .alu_c_in(alu_c_in), .alu_c_out(alu_c_out), .alu_out(alu_out),
    .alu_V(alu_V), .alu_Z(alu_Z), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_z(rsp_z));

  // external n-bit ALU: SUB is in0 + ~in1 + c_in
  always_comb begin
    y = alu_ctrl == 3'b001 ? ~alu_in1 : alu_in1;
    s = {1'b0, alu_in0} + {1'b0, y} + (N+1)'(alu_c_in);
    alu_out = alu_ctrl[2:1] == 2'b00 ? s[N-1:0] : alu_ctrl == 3'b010 ? alu_in0 | alu_in1 :
              alu_ctrl == 3'b011 ? alu_in0 | ~alu_in1 : alu_ctrl == 3'b100 ? alu_in0 & alu_in1 :
              alu_ctrl == 3'b101 ? alu_in0 & ~alu_in1 : alu_ctrl == 3'b110 ? ~alu_in0 : ~alu_in1;
    alu_c_out = alu_ctrl[2:1] == 2'b00 && s[N];
    alu_V = alu_ctrl[2:1] == 2'b00 && alu_in0[N-1] == y[N-1] && s[N-1] != alu_in0[N-1];
    alu_Z = alu_out == '0;
  end

  typedef struct {logic [W-1:0] r; logic c, v, z; int t;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0;
  logic pv = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, logic ci);
    exp_t e;
    logic [W:0] sum;
    sum = op == 3'b000 ? {1'b0, a} + {1'b0, b} + (W+1)'(ci) : {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    case (op)
      3'b000, 3'b001: e.r = sum[W-1:0];
      3'b010: e.r = a | b;
      3'b011: e.r = a | ~b;
      3'b100: e.r = a & b;
      3'b101: e.r = a & ~b;
      3'b110: e.r = ~a;
      default: e.r = ~b;
    endcase
    e.c = op[2:1] == 2'b00 && sum[W];
    e.v = op == 3'b000 ? a[W-1] == b[W-1] && e.r[W-1] != a[W-1] :
          op == 3'b001 ? a[W-1] != b[W-1] && e.r[W-1] != a[W-1] : 1'b0;
    e.z = e.r == '0;
    e.t = 0;
    return e;
  endfunction

  task automatic check(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) pv = 1'b0;
    else begin
      if (rsp_valid && !pv) begin
        if (q.size() == 0) check("unexpected_rsp", W'(rsp_valid), '0);
        else check("latency", W'(cyc - q[0].t), W'(WORDS));
      end
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("result", rsp_result, e.r);
        check("flags_cvz", W'({rsp_c, rsp_v, rsp_z}), W'({e.c, e.v, e.z}));
      end
      pv = rsp_valid;
    end
  end

  task automatic send(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b, logic ci, bit bp);
    exp_t e;
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    req_cin = ci;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        e = model(op, a, b, ci);
        e.t = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (bp) rsp_ready = 1'($urandom_range(0, 1));
        return;
      end
      @(posedge clk);
      #1 if (bp) rsp_ready = 1'($urandom_range(0, 1));
    end
    check("accept_timeout", W'(req_ready), W'(1));
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && q.size() > 0; i++) @(negedge clk);
    check("drain", W'(q.size()), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] held;
    logic [2:0] hf;
    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_cin = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", W'(rsp_valid), '0);
    check("reset_result", rsp_result, '0);
    check("reset_flags", W'({rsp_c, rsp_v, rsp_z}), '0);
    check("reset_ready", W'(req_ready), W'(1));
    check("reset_alu", W'({alu_in0, alu_ctrl, alu_c_in}), '0);
    @(posedge clk);
    #1;
    send(3'b000, 16'h00FF, 16'h0001, 1'b0, 0);
    send(3'b000, 16'h7FFF, 16'h0001, 1'b0, 0);
    send(3'b000, 16'hFFFF, 16'h0001, 1'b0, 0);
    send(3'b000, 16'h00FF, 16'h0000, 1'b1, 0);
    send(3'b001, 16'h1234, 16'h1234, 1'b0, 0);
    send(3'b001, 16'h0000, 16'h0001, 1'b0, 0);
    send(3'b001, 16'h8000, 16'h0001, 1'b1, 0);
    send(3'b010, 16'hF0F0, 16'h0F0F, 1'b1, 0);
    send(3'b100, 16'hF0F0, 16'h0F0F, 1'b0, 0);
    send(3'b110, 16'h00FF, 16'h1234, 1'b0, 0);
    send(3'b011, 16'h0F00, 16'h00FF, 1'b0, 0);
    send(3'b101, 16'hFFFF, 16'h00FF, 1'b0, 0);
    send(3'b111, 16'h0000, 16'hFFFF, 1'b0, 0);
    drain();
    rsp_ready = 1'b0;
    send(3'b000, 16'h1111, 16'h2222, 1'b0, 0);
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    check("bp_valid", W'(rsp_valid), W'(1));
    held = rsp_result;
    hf = {rsp_c, rsp_v, rsp_z};
    req_valid = 1'b1; req_op = 3'b001; req_a = 16'h0100; req_b = 16'h0001;
    repeat (5) begin
      @(negedge clk);
      check("bp_result_stable", rsp_result, held);
      check("bp_flags_stable", W'({rsp_c, rsp_v, rsp_z}), W'(hf));
      check("bp_not_ready", W'(req_ready), '0);
      check("bp_valid_held", W'(rsp_valid), W'(1));
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    send(3'b001, 16'h0100, 16'h0001, 1'b0, 0);
    drain();
    send(3'b000, 16'h1234, 16'h4321, 1'b0, 0);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_valid", W'(rsp_valid), '0);
    check("abort_ready", W'(req_ready), W'(1));
    check("abort_alu", W'({alu_in1, alu_ctrl, alu_c_in}), '0);
    check("abort_alu_in0", W'(alu_in0), '0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++)
      send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1);
    rsp_ready = 1'b1;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Requester-side driver for the n-bit bit-slice ALU. Accepts one multi-word operation per handshake and sequences it through the ALU one N-bit word per cycle, LSW first.
- Chains the ALU carry-out into the next word's carry-in.
- Assembles the full-width result and the C/V/Z flags, then returns them on a response handshake.
- Sits between the accumulator-processor control unit and an external alu_nbit instance, so that datapath can be wider than the ALU.

Parameters:
N, 8, ALU word width; must equal the connected ALU's n.
WORDS, 2, number of ALU words per operand; total width W = N*WORDS; WORDS >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  sequencer can accept a request.
req_op  input  3  ALU ctrl code: 000 ADD, 001 SUB, 010 OR, 011 OR-not, 100 AND, 101 AND-not, 110 NOT in0, 111 NOT in1.
req_a  input  W  operand A (ALU in0 side).
req_b  input  W  operand B (ALU in1 side).
req_cin  input  1  carry-in for ADD; ignored for all other ops.
alu_in0  output  N  to ALU in0.
alu_in1  output  N  to ALU in1.
alu_ctrl  output  3  to ALU ctrl.
alu_c_in  output  1  to ALU c_in.
alu_c_out  input  1  from ALU c_out.
alu_out  input  N  from ALU alu_out.
alu_V  input  1  from ALU V.
alu_Z  input  1  from ALU Z.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer takes result.
rsp_result  output  W  assembled result.
rsp_c  output  1  carry flag.
rsp_v  output  1  overflow flag.
rsp_z  output  1  zero flag (whole W-bit result is zero).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, rsp_valid=0, rsp_result=0, rsp_c/v/z=0, internal word index k=0, carry register=0.
- ALU drive outside EXEC: alu_in0/in1=0, alu_ctrl=000, alu_c_in=0.
- req_ready=1 iff state==IDLE and rst==0. It is combinational from state.
- States:
  - IDLE: on req_valid & req_ready, latch op/a/b/cin; set k=0; zero-accumulator=1; go to EXEC.
  - EXEC: drive alu_in0=a[k*N +: N], alu_in1=b[k*N +: N], alu_ctrl=op.
    - alu_c_in for k==0: req_cin for ADD, 1 for SUB, 0 for logic ops.
    - alu_c_in for k>0: registered alu_c_out of word k-1 (ADD/SUB only), else 0.
    - At each edge, capture alu_out into result word k and update the carry register with alu_c_out.
    - At each edge, zacc <= zacc & alu_Z.
    - If k==WORDS-1: capture alu_V, go to DONE. Otherwise k<=k+1.
  - DONE: rsp_valid=1; rsp_result and flags held stable. On rsp_ready, rsp_valid drops next cycle and state returns to IDLE.
- Latency: request accepted at edge T. EXEC occupies exactly WORDS cycles. rsp_valid is high starting the cycle after edge T+WORDS. Minimum request-to-request spacing is WORDS+2 cycles with rsp_ready held high.
- Flags:
  - ADD/SUB: rsp_c = last-word alu_c_out, rsp_v = last-word alu_V. SUB carry=1 means no borrow.
  - Logic ops: rsp_c=0, rsp_v=0.
  - rsp_z = AND of all words' alu_Z, for every op.
- Outputs rsp_result/flags keep their last values in IDLE; only rsp_valid qualifies them.
- req_valid while busy: ignored, no queuing. The requester must hold it until req_ready.
- Backpressure: DONE is held indefinitely while rsp_ready=0.
- Reset mid-operation: rst in any state discards the operation and returns to IDLE with reset values at the next edge. No partial response is issued.
- WORDS==1: a single EXEC cycle, with carry-in from req_cin/SUB rule only.

Optional Feature:
ALU_SEQ_EARLY_ACK_EN
- Defined: req_ready = (state==IDLE) | (state==DONE & rsp_ready). A request accepted in DONE while the response is consumed goes straight to EXEC. Back-to-back spacing becomes WORDS+1 cycles.
- Undefined: behaviour exactly as above, with req_ready only in IDLE.

Test Plan:
- N=8, WORDS=2: ADD a=0x00FF, b=0x0001, cin=0 -> rsp_result=0x0100, C=0, V=0, Z=0. rsp_valid first high 2 cycles after the accept edge.
- ADD a=0x7FFF, b=0x0001 -> 0x8000, V=1, C=0. ADD a=0xFFFF, b=0x0001 -> 0x0000, C=1, Z=1, V=0.
- SUB a=0x1234, b=0x1234 -> 0x0000, Z=1, C=1. SUB a=0x0000, b=0x0001 -> 0xFFFF, C=0, Z=0.
- OR a=0xF0F0, b=0x0F0F -> 0xFFFF, C=0, V=0. AND same operands -> 0x0000, Z=1. NOT in0 a=0x00FF -> 0xFF00.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> result/flags stable, req_ready=0, a second req_valid is not accepted. Release -> IDLE, then the second request is accepted.
- Assert rst during EXEC word 0 -> next cycle state IDLE, rsp_valid=0, req_ready=1, ALU outputs 0. No response is ever produced for the aborted request.
